// File: rtl/moore_pkg.sv
// Shared definitions for the Moore sequence-detector feeder blocks.
// Build option: define MOORE_SER_PARITY_EN to append an even-parity bit to every frame.
package moore_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT
`ifdef MOORE_SER_PARITY_EN
        ,
        PARITY = ST_PARITY
`endif
    } state_t;

endpackage

// File: rtl/ser_shift_reg.sv
// Datapath of the serializer: a left-aligned register holding the bits still to be sent,
// a down-counter of remaining data bits, and a running XOR of every bit put on the line.
module ser_shift_reg
    import moore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb,
    output logic             last,
    output logic             parity
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             par_q;

    // The MSB goes straight onto the line at load, so only the remaining bits are kept,
    // left-aligned, and the parity starts from that MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
        end else if (load) begin
            sr_q  <= {d[WIDTH-2:0], 1'b0};
            cnt_q <= CNT_INIT;
            par_q <= d[WIDTH-1];
        end else if (shift) begin
            sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
            par_q <= par_q ^ sr_q[WIDTH-1];
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign msb    = sr_q[WIDTH-1];
    assign last   = (cnt_q == '0);
    assign parity = par_q;

endmodule

// File: rtl/moore_bit_serializer.sv
// Parallel-to-serial feeder for the Moore detector: valid/ready word input, MSB-first
// registered bit stream with gapless back-to-back frames.
// Build option: define MOORE_SER_PARITY_EN to append an even-parity bit to every frame.
module moore_bit_serializer
    import moore_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start
);

    state_t state_q;
    logic   x_q;
    logic   xValid_q;
    logic   frameStart_q;

    logic   nextBit;
    logic   lastBit;
    logic   parityBit;
    logic   finalCycle;
    logic   accept;
    logic   shiftEn;

`ifdef MOORE_SER_PARITY_EN
    assign finalCycle = (state_q == PARITY);
`else
    logic unusedParity;
    assign unusedParity = parityBit;
    assign finalCycle   = (state_q == SHIFT) && lastBit;
`endif

    assign in_ready = (state_q == IDLE) || finalCycle;
    assign accept   = in_valid && in_ready;
    assign shiftEn  = (state_q == SHIFT) && !lastBit && !accept;

    ser_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .shift  (shiftEn),
        .d      (in_data),
        .msb    (nextBit),
        .last   (lastBit),
        .parity (parityBit)
    );

    // Frame sequencing; an accept always starts a fresh frame, even from the final cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            x_q          <= IDLE_BIT;
            xValid_q     <= 1'b0;
            frameStart_q <= 1'b0;
        end else if (accept) begin
            state_q      <= SHIFT;
            x_q          <= in_data[WIDTH-1];
            xValid_q     <= 1'b1;
            frameStart_q <= 1'b1;
        end else begin
            frameStart_q <= 1'b0;
            case (state_q)
                SHIFT: begin
                    if (!lastBit) begin
                        x_q      <= nextBit;
                        xValid_q <= 1'b1;
                    end else begin
`ifdef MOORE_SER_PARITY_EN
                        state_q  <= PARITY;
                        x_q      <= parityBit;
                        xValid_q <= 1'b1;
`else
                        state_q  <= IDLE;
                        x_q      <= IDLE_BIT;
                        xValid_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    x_q      <= IDLE_BIT;
                    xValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign x           = x_q;
    assign x_valid     = xValid_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_moore_bit_serializer.sv
// Self-checking bench for moore_bit_serializer (WIDTH=8); follows MOORE_SER_PARITY_EN if defined.
module tb_moore_bit_serializer;

    localparam int   WIDTH    = 8;
    localparam logic IDLE_BIT = 1'b0;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             frame_start;

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Each entry is one expected line cycle: {frame_start, x}; the front is the bit on x now.
    logic [1:0] expectQ[$];

    moore_bit_serializer #(
        .WIDTH    (WIDTH),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushFrame(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            expectQ.push_back({(i == WIDTH - 1), d[i]});
        end
`ifdef MOORE_SER_PARITY_EN
        expectQ.push_back({1'b0, ^d});
`endif
    endtask

    task automatic checkLine(input string tag);
        if (expectQ.size() > 0) begin
            checkOutput({tag, ".x_valid"}, 8'(x_valid), 8'd1);
            checkOutput({tag, ".x"}, 8'(x), 8'(expectQ[0][0]));
            checkOutput({tag, ".frame_start"}, 8'(frame_start), 8'(expectQ[0][1]));
        end else begin
            checkOutput({tag, ".x_valid"}, 8'(x_valid), 8'd0);
            checkOutput({tag, ".x"}, 8'(x), 8'(IDLE_BIT));
            checkOutput({tag, ".frame_start"}, 8'(frame_start), 8'd0);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, output logic accepted);
        logic expReady;
        in_valid = v;
        in_data  = d;
        #1;
        expReady = (expectQ.size() <= 1);
        checkOutput("in_ready", 8'(in_ready), 8'(expReady));
        accepted = v && expReady;
        @(posedge clk);
        if (expectQ.size() > 0) begin
            void'(expectQ.pop_front());
        end
        if (accepted) begin
            pushFrame(d);
        end
        @(negedge clk);
        checkLine("line");
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, acc);
        end
    endtask

    // Holds in_valid until the word is taken; a miss within the budget is a failure.
    task automatic sendWord(input logic [WIDTH-1:0] d);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 3 * WIDTH) begin
            applyStimulus(1'b1, d, acc);
            budget++;
        end
        checkOutput("accept_timeout", 8'(acc), 8'd1);
    endtask

    initial begin
        logic acc;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        checkOutput("rst.x", 8'(x), 8'(IDLE_BIT));
        checkOutput("rst.x_valid", 8'(x_valid), 8'd0);
        checkOutput("rst.in_ready", 8'(in_ready), 8'd1);
        checkOutput("rst.frame_start", 8'(frame_start), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        idleCycles(5);

        // Single words, including one with odd parity.
        sendWord(8'hA5);
        idleCycles(WIDTH + 2);
        sendWord(8'h07);
        idleCycles(WIDTH + 2);

        // Back-to-back with in_valid held high throughout.
        sendWord(8'hF0);
        sendWord(8'h0F);
        idleCycles(WIDTH + 2);

        // Backpressure: a mid-frame pulse must be ignored, then the held word taken at the end.
        sendWord(8'h5A);
        idleCycles(2);
        applyStimulus(1'b1, 8'h3C, acc);
        checkOutput("bp.pulse_ignored", 8'(acc), 8'd0);
        idleCycles(1);
        sendWord(8'h3C);
        idleCycles(WIDTH + 2);

        // Reset in the middle of a frame.
        sendWord(8'hFF);
        idleCycles(2);
        #2;
        reset = 1'b0;
        #1;
        expectQ.delete();
        checkOutput("midrst.x", 8'(x), 8'(IDLE_BIT));
        checkOutput("midrst.x_valid", 8'(x_valid), 8'd0);
        checkOutput("midrst.in_ready", 8'(in_ready), 8'd1);
        checkOutput("midrst.frame_start", 8'(frame_start), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        idleCycles(2);
        sendWord(8'h81);
        idleCycles(WIDTH + 2);

        // Random traffic with in_data wandering while not accepted.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(($urandom_range(0, 2) != 0), WIDTH'($urandom), acc);
        end
        idleCycles(WIDTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/moore_bit_serializer.md
# moore_bit_serializer

Upstream feeder for the Moore sequence-detector FSM. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, onto the single-bit serial line that drives the detector's `x` input. It supplies gapless back-to-back frames so the detector sees a continuous bit stream without a testbench-driven sequence.

## Interface
- `WIDTH`, 8: data word width in bits; legal values are ≥2.
- `IDLE_BIT`, 1'b0: level driven on `x` when no frame is active.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Asserting it (driving it low) immediately clears all state. State is released on the first rising clock edge after `reset` returns high.
- `in_data` input WIDTH: word to serialize.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a word this cycle.
- `x` output 1: serial bit, registered; connects to the detector's `x`.
- `x_valid` output 1: `x` carries a frame bit this cycle (data or parity).
- `frame_start` output 1: one-cycle pulse coincident with the first (MSB) bit of each frame.

## Operation
- States: `IDLE`, `SHIFT`, `PARITY`. The `PARITY` state exists only with the parity macro defined.
- Reset values: state `IDLE`, `x`=`IDLE_BIT`, `x_valid`=0, `frame_start`=0, `in_ready`=1, shift register 0, bit counter 0.
- `in_ready` is combinational from the state. It is 1 in `IDLE` and 1 in the final output cycle of a frame. The final output cycle is the last data bit, or the parity bit when parity is enabled. Otherwise `in_ready` is 0.
- Accept occurs when `in_valid && in_ready` on a rising edge.
  - The word is loaded into the shift register.
  - The bit counter is set to WIDTH-1.
  - The state goes to `SHIFT`.
  - `x` takes `in_data[WIDTH-1]`.
  - `x_valid`=1 and `frame_start`=1.
- In `SHIFT`, each edge shifts left by one, moves the next MSB to `x`, and decrements the counter. When the counter reaches 0, the last data bit is on `x`. The next state is then:
  - `PARITY`, if parity is enabled;
  - otherwise `SHIFT` for a new frame, if an accept occurs that edge;
  - otherwise `IDLE`.
- `PARITY` drives the parity bit for one cycle. From there the next state is `SHIFT`, on an accept, or `IDLE`.
- Returning to `IDLE` sets `x`=`IDLE_BIT` and `x_valid`=0.
- `in_data` is sampled only at accept, so changing it later has no effect.
- Holding `in_valid` high while `in_ready` is low does nothing, and no word is lost. The upstream source must hold `in_data` until accept.
- Bit counter width is `$clog2(WIDTH)`. The counter never wraps below 0.

## Timing
- Latency: a word accepted at edge k appears with its MSB on `x` at cycle k+1. Its LSB appears at k+WIDTH, and parity, when enabled, at k+WIDTH+1.
- Throughput is one word per WIDTH cycles, or WIDTH+1 with parity, with no idle gap under continuous `in_valid`.
- Back-to-back frames: an accept in the final cycle produces `frame_start`=1 on the very next cycle, with `x_valid` staying 1 throughout.
- `frame_start` is 0 in every cycle except the first bit of each frame.
- Reset mid-frame aborts the frame immediately (asynchronously) and returns all outputs to their reset values. No partial-frame resumption occurs.

## Configuration
- `MOORE_SER_PARITY_EN` defined:
  - one extra even-parity bit follows each word, equal to the XOR of all data bits;
  - `PARITY` state is present;
  - frame length is WIDTH+1.
- Not defined:
  - no `PARITY` state;
  - frame length is WIDTH;
  - the final output cycle is the LSB.

## Structure
- Shared package `moore_pkg` holds:
  - state encoding localparams: `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_PARITY`=2'd2;
  - the default `WIDTH`.
- One sub-module, `ser_shift_reg`, contains the loadable left-shift register, the down-counter and the running-parity accumulator. Its ports are `load`, `shift`, `d`, `msb`, `last` and `parity`. The top level holds the FSM and the handshake.

## Test plan
- Reset release: with `reset` low, `x`=0, `x_valid`=0 and `in_ready`=1. Release `reset` with `in_valid`=0 → outputs hold for 5 cycles.
- Single word, parity off, WIDTH=8: `in_data`=8'hA5 → `x`=1,0,1,0,0,1,0,1 on cycles 1–8. `frame_start` is high on cycle 1 only. `x_valid` goes low on cycle 9.
- Parity on: 8'hA5 → same 8 bits, then parity 0 on cycle 9. 8'h07 → parity bit 1.
- Back-to-back: 8'hF0 then 8'h0F with `in_valid` held high → 16 contiguous valid bits, `frame_start` on cycles 1 and 9, no gap.
- Backpressure: pulse `in_valid` with 8'h3C mid-frame → not accepted. It is accepted in the final cycle and its MSB appears next cycle.
- Reset mid-frame: assert `reset` after 3 bits of 8'hFF → `x`=0 and `x_valid`=0 immediately. After release, a new word 8'h81 serializes cleanly.
